bin_to_gray_counter: RTL

// - Registered binary-to-Gray encoder built around an up/down counter.
// - Produces pointer values that change by exactly one bit per step.

---
 rtl/gray_pkg.sv | 31 +++
 rtl/bin_to_gray_counter_if.sv | 24 ++
 rtl/bin_step_nxt.sv | 37 +++
 rtl/bin_to_gray_counter.sv | 57 +++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the pointer counter and its checkers.
// The helpers work on a wide word; callers zero-extend their operands and truncate the results.
package gray_pkg;

   localparam int MAX_W = 32;

   typedef logic [MAX_W-1:0] word_t;

   function automatic word_t bin2gray(input word_t b);
      return b ^ (b >> 1);
   endfunction

   // Mirrors gray_to_bin: each binary bit is the XOR of all Gray bits at or above it.
   function automatic word_t gray2bin(input word_t g);
      word_t b;
      b[MAX_W-1] = g[MAX_W-1];
      for (int i = MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic word_t term_up(input int w);
      return (word_t'(1) << w) - word_t'(1);
   endfunction

   function automatic word_t term_dn();
      return '0;
   endfunction

endpackage

// File: rtl/bin_to_gray_counter_if.sv
// Command and status bundle for the Gray pointer counter.
// inc and ld are single-cycle commands sampled on every rising edge with no backpressure; outputs update one edge later.
interface bin_to_gray_counter_if #(
   parameter int WIDTH = 3
);
   logic             inc;
   logic             dn;
   logic             ld;
   logic [WIDTH-1:0] ld_val;
   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] gr;
   logic             wrap;
   logic             at_end;

   modport master (
      output inc, dn, ld, ld_val,
      input  bin, gr, wrap, at_end
   );

   modport slave (
      input  inc, dn, ld, ld_val,
      output bin, gr, wrap, at_end
   );
endinterface

// File: rtl/bin_step_nxt.sv
// Next-state binary for the pointer counter: load/step/hold mux plus terminal-count handling.
// Also reports whether the current count sits at the terminal value for the selected direction.
module bin_step_nxt
   import gray_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter bit SAT   = 1'b0
) (
   input  logic             inc,
   input  logic             dn,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] bin_nxt,
   output logic             wrap_nxt,
   output logic             at_end
);

   localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(term_up(WIDTH));
   localparam logic [WIDTH-1:0] TERM_DN = WIDTH'(term_dn());

   always_comb begin
      bin_nxt  = bin;
      wrap_nxt = 1'b0;
      at_end   = dn ? (bin == TERM_DN) : (bin == TERM_UP);
      if (ld) begin
         bin_nxt = ld_val;
      end else if (inc) begin
         // Saturating build parks on the terminal value instead of rolling over.
         if (!(at_end && SAT)) begin
            bin_nxt  = dn ? (bin - 1'b1) : (bin + 1'b1);
            wrap_nxt = at_end;
         end
      end
   end

endmodule

// File: rtl/bin_to_gray_counter.sv
// Up/down binary counter with a registered Gray-coded copy, for clock-domain-crossing pointers.
// gr is encoded from the next-state binary and registered alongside bin, so it never glitches.
module bin_to_gray_counter
   import gray_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter bit SAT   = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   bin_to_gray_counter_if.slave  bus
);

   logic [WIDTH-1:0] bin_q;
   logic [WIDTH-1:0] gr_q;
   logic             wrap_q;
   logic [WIDTH-1:0] bin_nxt;
   logic [WIDTH-1:0] gr_nxt;
   logic             wrap_nxt;
   logic             at_end;

   bin_step_nxt #(
      .WIDTH (WIDTH),
      .SAT   (SAT)
   ) u_step (
      .inc      (bus.inc),
      .dn       (bus.dn),
      .ld       (bus.ld),
      .ld_val   (bus.ld_val),
      .bin      (bin_q),
      .bin_nxt  (bin_nxt),
      .wrap_nxt (wrap_nxt),
      .at_end   (at_end)
   );

   always_comb begin
      gr_nxt = WIDTH'(bin2gray(word_t'(bin_nxt)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q  <= '0;
         gr_q   <= '0;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_nxt;
         gr_q   <= gr_nxt;
         wrap_q <= wrap_nxt;
      end
   end

   assign bus.bin    = bin_q;
   assign bus.gr     = gr_q;
   assign bus.wrap   = wrap_q;
   assign bus.at_end = at_end;

endmodule
